// File: rtl/usb_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_rx_pkg : packet types, PID codes, error codes, field lengths         |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
package usb_rx_pkg;

  typedef enum logic [1:0] {
    PKT_NONE   = 2'b00,
    PKT_TOKEN  = 2'b01,
    PKT_DATA   = 2'b10,
    PKT_HSHAKE = 2'b11
  } pkt_type_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_PID_CHK   = 3'd1,
    ERR_PID_UNSUP = 3'd2,
    ERR_LENGTH    = 3'd3,
    ERR_CRC       = 3'd4,
    ERR_ABORT     = 3'd5,
    ERR_TIMEOUT   = 3'd6
  } err_code_t;

  localparam int PID_BITS    = 8;
  localparam int TOKEN_BITS  = 24;
  localparam int DATA_BITS   = 88;
  localparam int HSHAKE_BITS = 8;
  localparam int CRC5_BITS   = 5;
  localparam int CRC16_BITS  = 16;

  localparam int TOKEN_BODY_BITS = TOKEN_BITS - PID_BITS - CRC5_BITS;
  localparam int DATA_BODY_BITS  = DATA_BITS - PID_BITS - CRC16_BITS;

  function automatic pkt_type_t pid_class(input logic [3:0] pid);
    case (pid)
      PID_OUT, PID_IN, PID_SETUP:  pid_class = PKT_TOKEN;
      PID_DATA0, PID_DATA1:        pid_class = PKT_DATA;
      PID_ACK, PID_NAK, PID_STALL: pid_class = PKT_HSHAKE;
      default:                     pid_class = PKT_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sipo_register : serial-in parallel-out, shifts in at the MSB end         |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module sipo_register #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // MSB-end insertion lands the first bit at q[0] after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/rc_pkt_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rc_pkt_assembler : serial receive stream to parallel packet fields       |
// | Optional: RX_TIMEOUT_EN enables the stall timeout abort. Revision 1.0    |
// +--------------------------------------------------------------------------+
module rc_pkt_assembler
  import usb_rx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pkt,
  input  logic        s_in,
  input  logic        rx_wait,
  input  logic        end_pkt,
  input  logic        crc_error,
  input  logic        abort,
  output logic        pkt_valid,
  output logic        pkt_error,
  output logic [2:0]  err_code,
  output logic [1:0]  pkt_type,
  output logic [3:0]  rx_pid,
  output logic [6:0]  rx_addr,
  output logic [3:0]  rx_endp,
  output logic [63:0] rx_data
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PID        = 3'd1;
  localparam logic [2:0] S_TOKEN_BODY = 3'd2;
  localparam logic [2:0] S_DATA_BODY  = 3'd3;
  localparam logic [2:0] S_CRC        = 3'd4;
  localparam logic [2:0] S_DRAIN      = 3'd5;
  localparam logic [2:0] S_REPORT     = 3'd6;

  logic [2:0]  state, state_n;
  logic [6:0]  cnt, cnt_n;
  err_code_t   err, err_n, rep_code;
  pkt_type_t   cls, cls_n, new_class;
  logic        rep_valid, rep_error;
  logic [7:0]  pid_sr, pid_byte;
  logic [TOKEN_BODY_BITS-1:0] tok_sr;
  logic [DATA_BODY_BITS-1:0]  payload;
  logic [6:0]  crc_last;
  logic        busy, take, timeout;

  assign busy      = (state != S_IDLE) && (state != S_REPORT);
  assign take      = busy && !rx_wait && !end_pkt && !abort && !start_pkt;
  assign pid_byte  = {s_in, pid_sr[7:1]};
  assign new_class = pid_class(pid_byte[3:0]);
  assign crc_last  = (cls == PKT_TOKEN) ? 7'(CRC5_BITS - 1) : 7'(CRC16_BITS - 1);

  sipo_register #(
    .WIDTH (DATA_BODY_BITS)
  ) u_payload (
    .clk (clk),
    .rst (rst),
    .en  (take && (state == S_DATA_BODY)),
    .din (s_in),
    .q   (payload)
  );

`ifdef RX_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || !busy || take || end_pkt || start_pkt || abort) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign timeout = busy && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_n   = (state == S_REPORT) ? S_IDLE : state;
    cnt_n     = cnt;
    err_n     = err;
    cls_n     = cls;
    rep_valid = 1'b0;
    rep_error = 1'b0;
    rep_code  = ERR_NONE;
    if (busy && abort) begin
      rep_error = 1'b1;
      rep_code  = ERR_ABORT;
      state_n   = S_IDLE;
    end else if (start_pkt) begin
      // A restart truncates whatever packet was in flight.
      if (busy) begin
        rep_error = 1'b1;
        rep_code  = (err != ERR_NONE) ? err : ERR_LENGTH;
      end
      state_n = S_PID;
      cnt_n   = 7'd1;
      err_n   = ERR_NONE;
      cls_n   = PKT_NONE;
    end else if (busy && end_pkt) begin
      state_n = S_REPORT;
      cnt_n   = 7'd0;
      if (err != ERR_NONE) begin
        rep_error = 1'b1;
        rep_code  = err;
      end else if (state != S_DRAIN) begin
        rep_error = 1'b1;
        rep_code  = ERR_LENGTH;
      end else if (crc_error && (cls != PKT_HSHAKE)) begin
        rep_error = 1'b1;
        rep_code  = ERR_CRC;
      end else begin
        rep_valid = 1'b1;
      end
    end else if (take) begin
      cnt_n = cnt + 7'd1;
      case (state)
        S_PID: begin
          if (cnt == 7'(PID_BITS - 1)) begin
            cnt_n   = 7'd0;
            state_n = S_DRAIN;
            if (pid_byte[7:4] != ~pid_byte[3:0]) begin
              err_n = ERR_PID_CHK;
            end else if (new_class == PKT_NONE) begin
              err_n = ERR_PID_UNSUP;
            end else begin
              cls_n = new_class;
              if (new_class == PKT_TOKEN) state_n = S_TOKEN_BODY;
              if (new_class == PKT_DATA)  state_n = S_DATA_BODY;
            end
          end
        end
        S_TOKEN_BODY: begin
          if (cnt == 7'(TOKEN_BODY_BITS - 1)) begin
            cnt_n   = 7'd0;
            state_n = S_CRC;
          end
        end
        S_DATA_BODY: begin
          if (cnt == 7'(DATA_BODY_BITS - 1)) begin
            cnt_n   = 7'd0;
            state_n = S_CRC;
          end
        end
        S_CRC: begin
          if (cnt == crc_last) begin
            cnt_n   = 7'd0;
            state_n = S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt_n = cnt;
          if (err == ERR_NONE) err_n = ERR_LENGTH;
        end
        default: cnt_n = cnt;
      endcase
    end else if (timeout) begin
      rep_error = 1'b1;
      rep_code  = ERR_TIMEOUT;
      state_n   = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 7'd0;
      err       <= ERR_NONE;
      cls       <= PKT_NONE;
      pid_sr    <= 8'd0;
      tok_sr    <= '0;
      pkt_valid <= 1'b0;
      pkt_error <= 1'b0;
      err_code  <= 3'd0;
      pkt_type  <= 2'd0;
      rx_pid    <= 4'd0;
      rx_addr   <= 7'd0;
      rx_endp   <= 4'd0;
      rx_data   <= 64'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      err       <= err_n;
      cls       <= cls_n;
      pkt_valid <= rep_valid;
      pkt_error <= rep_error;
      if (start_pkt || (take && (state == S_PID))) pid_sr <= pid_byte;
      if (take && (state == S_TOKEN_BODY)) tok_sr <= {s_in, tok_sr[TOKEN_BODY_BITS-1:1]};
      if (rep_valid || rep_error) err_code <= rep_code;
      if (rep_valid) begin
        pkt_type <= cls;
        rx_pid   <= pid_sr[3:0];
        if (cls == PKT_TOKEN) begin
          rx_addr <= tok_sr[6:0];
          rx_endp <= tok_sr[10:7];
        end
        if (cls == PKT_DATA) rx_data <= payload;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rc_pkt_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rc_pkt_assembler : directed self-checking bench for rc_pkt_assembler  |
// | Revision            : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_rc_pkt_assembler;

  logic        clk = 1'b0;
  logic        rst, start_pkt, s_in, rx_wait, end_pkt, crc_error, abort;
  logic        pkt_valid, pkt_error;
  logic [2:0]  err_code;
  logic [1:0]  pkt_type;
  logic [3:0]  rx_pid;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_endp;
  logic [63:0] rx_data;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rc_pkt_assembler #(.TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst(rst), .start_pkt(start_pkt), .s_in(s_in), .rx_wait(rx_wait),
    .end_pkt(end_pkt), .crc_error(crc_error), .abort(abort),
    .pkt_valid(pkt_valid), .pkt_error(pkt_error), .err_code(err_code),
    .pkt_type(pkt_type), .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp),
    .rx_data(rx_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n bits LSB-first; optionally inserts an rx_wait cycle (with a
  // deliberately wrong s_in) before every wait_every-th bit.
  task automatic send_bits(input logic [127:0] v, input int n, input int wait_every,
                           input bit with_start);
    for (int i = 0; i < n; i++) begin
      if (wait_every != 0 && i != 0 && (i % wait_every) == 0) begin
        start_pkt = 1'b0; rx_wait = 1'b1; s_in = ~v[i];
        tick();
        rx_wait = 1'b0;
      end
      start_pkt = with_start && (i == 0);
      s_in      = v[i];
      tick();
    end
    start_pkt = 1'b0;
    s_in      = 1'b0;
  endtask

  task automatic finish_pkt(input logic crc);
    end_pkt = 1'b1; crc_error = crc; s_in = 1'b1;
    tick();
    end_pkt = 1'b0; crc_error = 1'b0; s_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_pkt = 0; s_in = 0; rx_wait = 0; end_pkt = 0; crc_error = 0; abort = 0;
    repeat (3) tick();
    vectors++;
    if ({pkt_valid, pkt_error, err_code, pkt_type, rx_pid, rx_addr, rx_endp, rx_data} !== 86'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0",
               {pkt_valid, pkt_error, err_code, pkt_type, rx_pid, rx_addr, rx_endp, rx_data});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ack();
    send_bits(128'h00D2, 8, 0, 1);
    vectors++;
    if (pkt_valid !== 1'b0) begin
      miscompares++; $display("FAIL ack_early: pkt_valid=%b want 0", pkt_valid);
    end
    finish_pkt(1'b0);
    vectors++;
    if ({pkt_valid, pkt_error, err_code, pkt_type, rx_pid} !== {1'b1, 1'b0, 3'd0, 2'b11, 4'b0010}) begin
      miscompares++;
      $display("FAIL ack_fields: got v=%b e=%b c=%0d t=%b p=%b want 1 0 0 11 0010",
               pkt_valid, pkt_error, err_code, pkt_type, rx_pid);
    end
    tick();
    vectors++;
    if (pkt_valid !== 1'b0) begin
      miscompares++; $display("FAIL ack_pulse_width: pkt_valid=%b want 0", pkt_valid);
    end
  endtask

  task automatic test_in_token();
    send_bits({5'b10101, 4'h1, 7'h05, 8'h69}, 24, 0, 1);
    finish_pkt(1'b0);
    vectors++;
    if ({pkt_valid, err_code, pkt_type, rx_pid, rx_addr, rx_endp} !==
        {1'b1, 3'd0, 2'b01, 4'b1001, 7'h05, 4'h1}) begin
      miscompares++;
      $display("FAIL in_token: got v=%b c=%0d t=%b p=%b a=%h e=%h want 1 0 01 1001 05 1",
               pkt_valid, err_code, pkt_type, rx_pid, rx_addr, rx_endp);
    end
    tick();
  endtask

  task automatic test_data0_wait();
    send_bits({16'hABCD, 64'h0000_0000_0000_3ffe, 8'hC3}, 88, 3, 1);
    finish_pkt(1'b0);
    vectors++;
    if ({pkt_valid, err_code, pkt_type, rx_pid, rx_data} !==
        {1'b1, 3'd0, 2'b10, 4'b0011, 64'h0000_0000_0000_3ffe}) begin
      miscompares++;
      $display("FAIL data0_wait: got v=%b c=%0d t=%b p=%b d=%h want 1 0 10 0011 3ffe",
               pkt_valid, err_code, pkt_type, rx_pid, rx_data);
    end
    vectors++;
    if ({rx_addr, rx_endp} !== {7'h05, 4'h1}) begin
      miscompares++;
      $display("FAIL data0_token_hold: got a=%h e=%h want 05 1", rx_addr, rx_endp);
    end
    tick();
  endtask

  task automatic test_bad_pid();
    send_bits(128'h0002, 8, 0, 1);
    finish_pkt(1'b0);
    vectors++;
    if ({pkt_valid, pkt_error, err_code} !== {1'b0, 1'b1, 3'd1}) begin
      miscompares++;
      $display("FAIL bad_pid: got v=%b e=%b c=%0d want 0 1 1", pkt_valid, pkt_error, err_code);
    end
    vectors++;
    if ({pkt_type, rx_pid, rx_addr, rx_endp, rx_data} !== {2'b10, 4'b0011, 7'h05, 4'h1, 64'h3ffe}) begin
      miscompares++;
      $display("FAIL bad_pid_hold: got t=%b p=%b a=%h e=%h d=%h want 10 0011 05 1 3ffe",
               pkt_type, rx_pid, rx_addr, rx_endp, rx_data);
    end
    tick();
  endtask

  task automatic test_short_token();
    send_bits({5'b00110, 4'h7, 7'h2A, 8'h69}, 23, 0, 1);
    finish_pkt(1'b0);
    vectors++;
    if ({pkt_error, err_code, rx_addr} !== {1'b1, 3'd3, 7'h05}) begin
      miscompares++;
      $display("FAIL short_token: got e=%b c=%0d a=%h want 1 3 05", pkt_error, err_code, rx_addr);
    end
    tick();
  endtask

  task automatic test_data1_crc();
    send_bits({16'h1234, 64'h0123_4567_89AB_CDEF, 8'h4B}, 88, 0, 1);
    finish_pkt(1'b1);
    vectors++;
    if ({pkt_valid, pkt_error, err_code, rx_pid, rx_data} !== {1'b0, 1'b1, 3'd4, 4'b0011, 64'h3ffe}) begin
      miscompares++;
      $display("FAIL data1_crc: got v=%b e=%b c=%0d p=%b d=%h want 0 1 4 0011 3ffe",
               pkt_valid, pkt_error, err_code, rx_pid, rx_data);
    end
    tick();
  endtask

  task automatic test_abort();
    send_bits({16'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hC3}, 40, 0, 1);
    abort = 1'b1; s_in = 1'b1;
    tick();
    abort = 1'b0; s_in = 1'b0;
    vectors++;
    if ({pkt_valid, pkt_error, err_code} !== {1'b0, 1'b1, 3'd5}) begin
      miscompares++;
      $display("FAIL abort: got v=%b e=%b c=%0d want 0 1 5", pkt_valid, pkt_error, err_code);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if ({pkt_valid, pkt_error} !== 2'b00) begin
      miscompares++; $display("FAIL abort_idle: got v=%b e=%b want 0 0", pkt_valid, pkt_error);
    end
    send_bits(128'h00D2, 1, 0, 1);
    vectors++;
    if (pkt_error !== 1'b0) begin
      miscompares++; $display("FAIL abort_not_idle: pkt_error=%b want 0", pkt_error);
    end
    send_bits(128'h0069, 7, 0, 0);
    finish_pkt(1'b0);
    vectors++;
    if ({pkt_valid, err_code, pkt_type, rx_pid, rx_data} !== {1'b1, 3'd0, 2'b11, 4'b0010, 64'h3ffe}) begin
      miscompares++;
      $display("FAIL abort_then_ack: got v=%b c=%0d t=%b p=%b d=%h want 1 0 11 0010 3ffe",
               pkt_valid, err_code, pkt_type, rx_pid, rx_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    send_bits({5'b10101, 4'h3, 7'h11, 8'hE1}, 10, 0, 1);
    send_bits(128'h00D2, 1, 0, 1);
    vectors++;
    if ({pkt_error, err_code} !== {1'b1, 3'd3}) begin
      miscompares++; $display("FAIL restart_report: got e=%b c=%0d want 1 3", pkt_error, err_code);
    end
    send_bits(128'h0069, 7, 0, 0);
    finish_pkt(1'b1);
    vectors++;
    if ({pkt_valid, err_code, pkt_type, rx_pid} !== {1'b1, 3'd0, 2'b11, 4'b0010}) begin
      miscompares++;
      $display("FAIL restart_ack_crc_ignored: got v=%b c=%0d t=%b p=%b want 1 0 11 0010",
               pkt_valid, err_code, pkt_type, rx_pid);
    end
    tick();
    send_bits({1'b1, 8'hD2}, 9, 0, 1);
    finish_pkt(1'b0);
    vectors++;
    if ({pkt_valid, pkt_error, err_code} !== {1'b0, 1'b1, 3'd3}) begin
      miscompares++;
      $display("FAIL long_ack: got v=%b e=%b c=%0d want 0 1 3", pkt_valid, pkt_error, err_code);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    send_bits({5'b10101, 4'h1, 7'h05, 8'h69}, 10, 0, 1);
    rst = 1'b1;
    tick();
    vectors++;
    if ({pkt_valid, pkt_error, err_code, pkt_type, rx_pid, rx_addr, rx_endp, rx_data} !== 86'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got %h want 0",
               {pkt_valid, pkt_error, err_code, pkt_type, rx_pid, rx_addr, rx_endp, rx_data});
    end
    rst = 1'b0;
    tick();
    send_bits(128'h00D2, 8, 0, 1);
    finish_pkt(1'b0);
    vectors++;
    if ({pkt_valid, pkt_error, err_code, pkt_type, rx_data} !== {1'b1, 1'b0, 3'd0, 2'b11, 64'd0}) begin
      miscompares++;
      $display("FAIL rst_then_ack: got v=%b e=%b c=%0d t=%b d=%h want 1 0 0 11 0",
               pkt_valid, pkt_error, err_code, pkt_type, rx_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    send_bits(128'h00C3, 8, 0, 1);
    rx_wait = 1'b1;
`ifdef RX_TIMEOUT_EN
    repeat (31) begin
      tick();
      if (pkt_error) early = 1'b1;
    end
    vectors++;
    if (early) begin
      miscompares++; $display("FAIL timeout_early: pkt_error seen before 32 stall cycles want none");
    end
    tick();
    vectors++;
    if ({pkt_error, err_code} !== {1'b1, 3'd6}) begin
      miscompares++; $display("FAIL timeout: got e=%b c=%0d want 1 6", pkt_error, err_code);
    end
    rx_wait = 1'b0;
    tick();
`else
    repeat (40) begin
      tick();
      if (pkt_error || pkt_valid) early = 1'b1;
    end
    vectors++;
    if (early) begin
      miscompares++; $display("FAIL no_timeout: pulse seen during stall want none");
    end
    rx_wait = 1'b0;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    vectors++;
    if ({pkt_error, err_code} !== {1'b1, 3'd5}) begin
      miscompares++; $display("FAIL stall_abort: got e=%b c=%0d want 1 5", pkt_error, err_code);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_ack();
    test_in_token();
    test_data0_wait();
    test_bad_pid();
    test_short_token();
    test_data1_crc();
    test_abort();
    test_back_to_back();
    test_rst_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
